instr_prefetch_queue: RTL and testbench
=======================================

# instr_prefetch_queue

Parametrised instruction register and prefetch queue that holds up to DEPTH fetched instruction words and presents the oldest one, already split into opcode and register-address fields, to the control unit. It replaces the single-entry instruction register between instruction memory and the control/datapath. Fetch can therefore run ahead of execution, and a taken branch can discard prefetched words with a flush.

## Interface
Parameters:
- IW, 16, instruction word width; must equal OPW + 3*RW
- OPW, 4, opcode field width (instruction bits IW-1 .. IW-OPW)
- RW, 4, register address field width for DA, AA and BA
- DEPTH, 4, queue entries; power of two, >= 2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- IL  in  1  instruction load request (push valid)
- IR  in  IW  instruction word to load
- il_ready  out  1  queue can accept a load this cycle
- next  in  1  control unit consumes the head instruction (pop)
- flush  in  1  discard all queued instructions
- ir_valid  out  1  head instruction present
- instr  out  IW  raw head instruction word
- opcode  out  OPW  head bits [IW-1 : IW-OPW]
- DA  out  RW  head bits [3*RW-1 : 2*RW]
- AA  out  RW  head bits [2*RW-1 : RW]
- BA  out  RW  head bits [RW-1 : 0]
- count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH

## Operation
- Storage is a circular buffer with write pointer wp, read pointer rp and count. Pointers wrap modulo DEPTH.
- Push is accepted when IL && il_ready. IR is written at wp, and wp increments.
- Pop is accepted when next && ir_valid. rp increments. next while empty is ignored.
- il_ready = (count != DEPTH). It does not depend on next in the same cycle, so a full queue refuses a load even when a pop happens that cycle.
- Push and pop in the same cycle: both take effect and count is unchanged.
- flush has the highest priority. wp, rp and count go to 0, and any same-cycle push or pop is discarded. Stored data is not cleared.
- ir_valid = (count != 0).
- instr and the decoded fields come combinationally from the head entry at rp. When ir_valid = 0, instr, opcode, DA, AA and BA are forced to 0.
- Asserting reset (low) at any time, including mid-operation, clears pointers and count immediately. Stored words are don't-care after reset but are never visible, because the outputs are forced to 0.

## Timing
- Reset values: il_ready = 1, ir_valid = 0, count = 0, instr/opcode/DA/AA/BA = 0.
- Load-to-visible latency is 1 cycle. A word pushed at edge N into an empty queue appears on instr and the fields after edge N; there is no same-cycle bypass.
- Pop latency is 1 cycle. After the popping edge, the next-oldest word, or zeros if the queue is now empty, appears on the outputs.
- il_ready deasserts the cycle count reaches DEPTH and reasserts the cycle after the first pop or flush.
- Steady state sustains one load and one consume per cycle with no bubbles while 0 < count < DEPTH.
- Release of reset is synchronised externally. The first accepted push is at the first rising edge with reset high.

## Test plan
- Reset and single load: hold reset low, check all outputs 0 and il_ready = 1. Release reset and load IR = 16'h8006 for 1 cycle. Next cycle: ir_valid = 1, opcode = 8, DA = 0, AA = 0, BA = 6, count = 1.
- Fill and overflow: load 16'h1234, 16'h2345, 16'h3456, 16'h4567, then 16'h5678 with next = 0. Required: count = 4, il_ready = 0, the fifth word is not stored. Then pop 4 times; the heads must read opcode/DA/AA/BA = 1/2/3/4, 2/3/4/5, 3/4/5/6, 4/5/6/7 in order, after which ir_valid = 0.
- Simultaneous push/pop with wrap: keep count = 2 while streaming 10 words with IL and next asserted every cycle. Required: count stays 2, words emerge in order, and pointers wrap past DEPTH without loss.
- Full plus pop: with count = 4, assert IL (16'hABCD) and next together. Required: pop only, count = 3, 16'hABCD is absent from the queue.
- Flush priority: with count = 3, assert flush, IL (16'h7777) and next in the same cycle. Required: count = 0, ir_valid = 0, all fields 0. A load the following cycle makes 16'h7777 the head only if it is pushed again.
- Mid-operation reset: with count = 2, pull reset low between clock edges. Required: outputs go to reset values immediately, without waiting for a clock edge, and remain there until reset is released.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: circular prefetch queue presenting the oldest fetched word, pre-split into opcode/DA/AA/BA
module instr_prefetch_queue #(
  parameter int IW    = 16,
  parameter int OPW   = 4,
  parameter int RW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     IL,
  input  logic [IW-1:0]            IR,
  output logic                     il_ready,
  input  logic                     next,
  input  logic                     flush,
  output logic                     ir_valid,
  output logic [IW-1:0]            instr,
  output logic [OPW-1:0]           opcode,
  output logic [RW-1:0]            DA,
  output logic [RW-1:0]            AA,
  output logic [RW-1:0]            BA,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  logic [IW-1:0] w_head;

  assign il_ready = r_count != CW'(DEPTH);
  assign ir_valid = r_count != '0;
  assign w_push   = IL && il_ready && !flush;
  assign w_pop    = next && ir_valid && !flush;
  assign count    = r_count;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end

  // storage is never reset; stale words are hidden by the ir_valid gating below
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= IR;

  always_comb begin
    w_head = ir_valid ? r_mem[r_rp] : '0;
    instr  = w_head;
    opcode = w_head[IW-1:IW-OPW];
    DA     = w_head[3*RW-1:2*RW];
    AA     = w_head[2*RW-1:RW];
    BA     = w_head[RW-1:0];
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed steps against a queue model of the prefetch buffer
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        IL = 1'b0, next = 1'b0, flush = 1'b0;
  logic [15:0] IR = '0;
  logic        il_ready, ir_valid;
  logic [15:0] instr;
  logic [3:0]  opcode, DA, AA, BA;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] q[$];

  instr_prefetch_queue #(.IW(16), .OPW(4), .RW(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .IL(IL), .IR(IR), .il_ready(il_ready),
    .next(next), .flush(flush), .ir_valid(ir_valid), .instr(instr),
    .opcode(opcode), .DA(DA), .AA(AA), .BA(BA), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] h;
    h = (q.size() != 0) ? q[0] : 16'h0;
    chk({tag, ".count"},    32'(count),    32'(q.size()));
    chk({tag, ".il_ready"}, 32'(il_ready), 32'(q.size() != DEPTH));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(q.size() != 0));
    chk({tag, ".instr"},    32'(instr),    32'(h));
    chk({tag, ".opcode"},   32'(opcode),   32'(h[15:12]));
    chk({tag, ".DA"},       32'(DA),       32'(h[11:8]));
    chk({tag, ".AA"},       32'(AA),       32'(h[7:4]));
    chk({tag, ".BA"},       32'(BA),       32'(h[3:0]));
  endtask

  // drive one cycle, update the model as the queue should, then check after the edge
  task automatic step(input string tag, input logic il, input logic [15:0] ir,
                      input logic nx, input logic fl);
    bit push, pop;
    IL = il; IR = ir; next = nx; flush = fl;
    push = il && (q.size() < DEPTH) && !fl;
    pop  = nx && (q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(ir);
    end
    #1;
    IL = 0; next = 0; flush = 0;
    check_all(tag);
  endtask

  initial begin
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    #4;
    step("load8006", 1, 16'h8006, 0, 0);
    chk("load.opcode", 32'(opcode), 32'h8);
    chk("load.BA", 32'(BA), 32'h6);
    chk("load.count", 32'(count), 32'd1);
    step("pop8006", 0, 16'h0, 1, 0);
    step("pop_empty", 0, 16'h0, 1, 0);

    step("fill1", 1, 16'h1234, 0, 0);
    step("fill2", 1, 16'h2345, 0, 0);
    step("fill3", 1, 16'h3456, 0, 0);
    step("fill4", 1, 16'h4567, 0, 0);
    chk("full.il_ready", 32'(il_ready), 32'h0);
    step("overflow", 1, 16'h5678, 0, 0);
    chk("overflow.count", 32'(count), 32'd4);
    chk("overflow.head", 32'(instr), 32'h1234);
    for (int i = 0; i < 4; i++) step("drain", 0, 16'h0, 1, 0);
    chk("drained.ir_valid", 32'(ir_valid), 32'h0);

    step("pre1", 1, 16'hA100, 0, 0);
    step("pre2", 1, 16'hA201, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step("stream", 1, 16'hB000 + 16'(i * 16'h1111), 1, 0);
      chk("stream.count", 32'(count), 32'd2);
    end

    step("top3", 1, 16'hC3C3, 0, 0);
    step("top4", 1, 16'hC4C4, 0, 0);
    step("full_pop", 1, 16'hABCD, 1, 0);
    chk("full_pop.count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("full_pop.noabcd", 32'(instr == 16'hABCD), 32'h0);
      step("fp_drain", 0, 16'h0, 1, 0);
    end

    step("f1", 1, 16'h1111, 0, 0);
    step("f2", 1, 16'h2222, 0, 0);
    step("f3", 1, 16'h3333, 0, 0);
    step("flush", 1, 16'h7777, 1, 1);
    chk("flush.count", 32'(count), 32'd0);
    step("postflush_idle", 0, 16'h0, 0, 0);
    step("postflush_load", 1, 16'h7777, 0, 0);
    chk("postflush.head", 32'(instr), 32'h7777);

    step("r2", 1, 16'h9E21, 0, 0);
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    check_all("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_all("held_reset");
    @(negedge clk);
    reset = 1'b1;
    #4;
    step("after_reset", 1, 16'h5A5A, 0, 0);
    step("after_reset_pop", 0, 16'h0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
